uart_rx_frame_ctrl: RTL
=======================

Name: uart_rx_frame_ctrl

Overview:
Receive-side frame sequencer for the UART pattern-matching path. It sits between the baud generator's oversample tick and the SIPO shift register, and replaces free-running per-tick sampling with start-bit detection, mid-bit data sampling and stop-bit checking. It drives the SIPO enable and serial bit, and emits a per-byte valid strobe used to qualify the pattern detector. It also flags framing errors.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per UART bit period; even, at least 4
DATA_BITS, 8, data bits per frame; LSB first; no parity

Ports:
sys_clk  input  1  system clock (25 MHz)
reset  input  1  asynchronous, active-low reset
baud_tick  input  1  one-sys_clk-wide pulse, OVERSAMPLE per bit period
rx_in  input  1  raw UART line; idle high; asynchronous to sys_clk
shift_en  output  1  one-cycle SIPO enable per sampled data bit
shift_bit  output  1  sampled data bit; valid while shift_en=1
byte_valid  output  1  one-cycle pulse when a frame completes with a good stop bit
data_out  output  DATA_BITS  last good byte; bit 0 is the first received bit
frame_err  output  1  one-cycle pulse when the stop bit samples low
busy  output  1  high whenever state != IDLE

Behaviour:
- Synchronizer: rx_in passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value rx_s.
- Tick gating: counters and state advance only on cycles with baud_tick=1.
- Registers: os_cnt is log2(OVERSAMPLE) bits; bit_cnt is log2(DATA_BITS)+1 bits; shift_reg is DATA_BITS wide.
- Reset values (reset=0, asynchronous): state=IDLE, os_cnt=0, bit_cnt=0, shift_reg=0. All outputs are 0, including data_out.
- IDLE:
  - On a tick with rx_s=0: go to START, os_cnt=0.
- START:
  - On a tick where os_cnt==OVERSAMPLE/2-1 and rx_s=1: glitch; return to IDLE with no error pulse.
  - On a tick where os_cnt==OVERSAMPLE/2-1 and rx_s=0: go to DATA, os_cnt=0, bit_cnt=0.
  - Any other tick: os_cnt+1.
- DATA:
  - On a tick where os_cnt==OVERSAMPLE-1 (mid-bit): os_cnt=0; sample rx_s into shift_reg MSB and shift right; pulse shift_en with shift_bit=rx_s; bit_cnt+1.
  - When bit_cnt reaches DATA_BITS: go to STOP.
  - Any other tick: os_cnt+1.
- STOP:
  - On a tick where os_cnt==OVERSAMPLE-1 and rx_s=1: data_out<=shift_reg, pulse byte_valid, go to IDLE.
  - On a tick where os_cnt==OVERSAMPLE-1 and rx_s=0: pulse frame_err, go to BREAK; data_out is unchanged.
  - Any other tick: os_cnt+1.
- BREAK:
  - On a tick with rx_s=1: go to IDLE.
  - Otherwise stay. A held-low line therefore produces exactly one frame_err and no new frames.
- Output timing: all outputs are registered.
  - shift_en, shift_bit, byte_valid and frame_err assert in the sys_clk cycle after the qualifying tick and last exactly 1 cycle.
  - data_out updates in the same cycle byte_valid asserts.
- Latency: rx_in falling edge to START takes 2 sys_clk (synchronizer) plus up to one tick period.
- Simultaneous events: byte_valid and frame_err are mutually exclusive. shift_en never coincides with byte_valid.
- Back-to-back frames: IDLE is re-entered on the stop-bit mid-sample tick. A start edge on the next tick is accepted, so there is no dead bit.
- Mid-operation reset: asserting reset in any state aborts the frame immediately with no pulses. After release, a new frame must begin from IDLE.
- busy is high from entry to START through the IDLE return, including BREAK.

Test Plan:
1. OVERSAMPLE=16, baud_tick every 4 sys_clk; send frame 0x5A with stop=1 -> 8 shift_en pulses with shift_bit=0,1,0,1,1,0,1,0; one byte_valid; data_out=0x5A; frame_err=0; busy low after stop.
2. Drive rx_in low for 3 ticks, then high -> busy rises, then returns to 0 at the mid-start check; no shift_en, byte_valid or frame_err.
3. Send 0x00 with stop bit 0, then hold line low for 40 ticks -> exactly one frame_err; no byte_valid; data_out keeps its prior value; busy stays 1 until the line rises, then falls.
4. Send 0xA5 and 0x3C back-to-back with a single stop bit -> two byte_valid pulses; data_out=0xA5, then 0x3C; 16 shift_en total; no frame_err.
5. Assert reset after 4 data bits of 0xFF -> all outputs 0 immediately, data_out=0x00. Then send 0x81 -> byte_valid with data_out=0x81.
6. Toggle rx_in with baud_tick held 0 for 100 cycles -> no state change; busy=0; no output pulses.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start-bit qualification, mid-bit data sampling
// into a SIPO enable stream, stop-bit check with framing-error/break handling.
module uart_rx_frame_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic                 shift_en,
    output logic                 shift_bit,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS) + 1;

    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic                 sync1_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 shift_en_q, shift_en_d;
    logic                 shift_bit_q, shift_bit_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q;

    // Idle-high line: synchronizer flops reset to 1 so reset release is not a start edge.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        os_cnt_d     = os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_reg_d  = shift_reg_q;
        data_d       = data_q;
        shift_en_d   = 1'b0;
        shift_bit_d  = 1'b0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d  = START;
                        os_cnt_d = '0;
                    end
                end
                START: begin
                    if (os_cnt_q == OS_HALF) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            os_cnt_d  = '0;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    // Counter was cleared at mid-start, so wrapping lands mid-bit.
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d    = '0;
                        shift_reg_d = {rx_s_q, shift_reg_q[DATA_BITS-1:1]};
                        shift_en_d  = 1'b1;
                        shift_bit_d = rx_s_q;
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        if (rx_s_q) begin
                            data_d       = shift_reg_q;
                            byte_valid_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BRK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_reg_q  <= '0;
            data_q       <= '0;
            shift_en_q   <= 1'b0;
            shift_bit_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_reg_q  <= shift_reg_d;
            data_q       <= data_d;
            shift_en_q   <= shift_en_d;
            shift_bit_q  <= shift_bit_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign shift_en   = shift_en_q;
    assign shift_bit  = shift_bit_q;
    assign byte_valid = byte_valid_q;
    assign data_out   = data_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
